// File: rtl/result_bcd_conv.sv
// result_bcd_conv
// Sequential binary-to-BCD converter (shift-and-add-3) between the calculator
// arithmetic core and the seven-segment display driver.
//
// Ports:
//   clk_db             calculator logic clock
//   rst                synchronous reset, active-high
//   start              single-cycle request, sampled only while idle
//   mag_in             unsigned magnitude (value = mag_in / 10^frac_in)
//   neg_in             sign of the result, 1 = negative
//   frac_in            fractional digit count 0..6 (7 is clamped to 6)
//   busy               high from the cycle after acceptance until done
//   done               one-cycle pulse, outputs update on the same edge
//   result_digits      packed BCD digits, [3:0] is least significant
//   is_result_negative registered sign (never set for zero or overflow)
//   decimal_pos        registered, clamped copy of frac_in
//   digit_en           1 = digit shown, 0 = leading-zero blank
//   overflow           magnitude does not fit in NDIG digits
module result_bcd_conv #(
  parameter int BIN_W = 24,
  parameter int NDIG  = 7
) (
  input  logic                clk_db,
  input  logic                rst,
  input  logic                start,
  input  logic [BIN_W-1:0]    mag_in,
  input  logic                neg_in,
  input  logic [2:0]          frac_in,
  output logic                busy,
  output logic                done,
  output logic [4*NDIG-1:0]   result_digits,
  output logic                is_result_negative,
  output logic [2:0]          decimal_pos,
  output logic [NDIG-1:0]     digit_en,
  output logic                overflow
);

  // One extra digit above the displayed ones catches overflow.
  localparam int ACC_W = 4 * (NDIG + 1);
  localparam int CNT_W = $clog2(BIN_W + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] FIN   = 2'd2;

  logic [1:0]       state;
  logic [ACC_W-1:0] acc;
  logic [BIN_W-1:0] bin;
  logic [CNT_W-1:0] cnt;
  logic             neg_lat;
  logic [2:0]       frac_lat;

  logic [ACC_W-1:0] acc_adj;
  logic [NDIG-1:0]  lz_mask;
  logic             lz_seen;
  logic             acc_ovf;
  logic             acc_zero;
  logic [2:0]       frac_clamped;

  assign frac_clamped = (frac_in == 3'd7) ? 3'd6 : frac_in;

  // Add-3 correction: any nibble >= 5 would exceed 9 after the shift.
  always_comb begin
    acc_adj = acc;
    for (int i = 0; i <= NDIG; i++) begin
      if (acc[4*i +: 4] >= 4'd5) begin
        acc_adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
      end else begin
        acc_adj[4*i +: 4] = acc[4*i +: 4];
      end
    end
  end

  // Leading-zero mask: scan from the top digit, enabling once a nonzero
  // digit is seen; the units digit and fractional digits are always shown.
  always_comb begin
    lz_seen = 1'b0;
    lz_mask = {NDIG{1'b0}};
    for (int i = NDIG - 1; i >= 0; i--) begin
      lz_seen    = lz_seen | (acc[4*i +: 4] != 4'd0);
      lz_mask[i] = lz_seen | (i <= int'(frac_lat));
    end
  end

  assign acc_ovf  = |acc[ACC_W-1:4*NDIG];
  assign acc_zero = (acc[4*NDIG-1:0] == {(4*NDIG){1'b0}});

  // Conversion FSM and registered outputs.
  always_ff @(posedge clk_db) begin
    if (rst) begin
      state              <= IDLE;
      busy               <= 1'b0;
      done               <= 1'b0;
      overflow           <= 1'b0;
      is_result_negative <= 1'b0;
      decimal_pos        <= 3'd0;
      result_digits      <= {(4*NDIG){1'b0}};
      digit_en           <= {{(NDIG-1){1'b0}}, 1'b1};
      acc                <= {ACC_W{1'b0}};
      bin                <= {BIN_W{1'b0}};
      cnt                <= {CNT_W{1'b0}};
      neg_lat            <= 1'b0;
      frac_lat           <= 3'd0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            bin      <= mag_in;
            neg_lat  <= neg_in;
            frac_lat <= frac_clamped;
            acc      <= {ACC_W{1'b0}};
            cnt      <= CNT_W'(BIN_W);
            busy     <= 1'b1;
            state    <= SHIFT;
          end else begin
            state <= IDLE;
          end
        end
        SHIFT: begin
          // {acc, bin} shifted left by one after correction.
          acc <= {acc_adj[ACC_W-2:0], bin[BIN_W-1]};
          bin <= {bin[BIN_W-2:0], 1'b0};
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            state <= FIN;
          end else begin
            state <= SHIFT;
          end
        end
        FIN: begin
          done        <= 1'b1;
          busy        <= 1'b0;
          state       <= IDLE;
          decimal_pos <= frac_lat;
          overflow    <= acc_ovf;
          if (acc_ovf) begin
            result_digits      <= {(4*NDIG){1'b1}};
            is_result_negative <= 1'b0;
            digit_en           <= {NDIG{1'b1}};
          end else begin
            result_digits      <= acc[4*NDIG-1:0];
            // A zero result is never shown as negative.
            is_result_negative <= neg_lat & ~acc_zero;
            digit_en           <= lz_mask;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
